// File: rtl/mem_mul_sequencer.sv
// mem_mul_sequencer
//   Controller for the 128x52 single-port register-file macro and the 26x26
//   multiplier. It runs an in-place loop over an address range: each word
//   {hi[51:26], lo[25:0]} is read, multiplied (hi*lo) and written back.
//   A host read/write port shares the macro and is served only when the loop
//   is idle.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   start, base_addr, len      loop request, first word address, word count
//   busy, done, count          loop in progress, completion pulse, words written
//   host_req/wr/addr/wdata     host access request (held until host_gnt)
//   host_gnt, host_rvalid      access performed / mem_do holds host read data
//   mem_do                     macro DO (feeds the multiplier directly)
//   mul_out                    multiplier product
//   mem_din                    macro DIN
//   RA, CA, NCE, NWRT          registered macro control pins
module mem_mul_sequencer #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 52
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    len,
    output logic          busy,
    output logic          done,
    output logic [7:0]    count,
    input  logic          host_req,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    input  logic [DW-1:0] mem_do,
    input  logic [DW-1:0] mul_out,
    output logic [DW-1:0] mem_din,
    output logic [4:0]    RA,
    output logic [1:0]    CA,
    output logic          NCE,
    output logic          NWRT
);

    localparam int unsigned WCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOST,
        ST_RD,
        ST_MWAIT,
        ST_WR,
        ST_FIN
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_cur;
    logic [7:0]     r_len;
    logic [7:0]     r_count;
    logic [WCW-1:0] r_wait;
    logic           r_busy;
    logic           r_done;
    logic           r_host_gnt;
    logic           r_host_rvalid;
    logic           r_host_wr;
    logic [DW-1:0]  r_wdata;
    logic [4:0]     r_ra;
    logic [1:0]     r_ca;
    logic           r_nce;
    logic           r_nwrt;

    logic [7:0]     w_len_clamp;
    logic [7:0]     w_count_inc;
    logic [AW-1:0]  w_cur_inc;
    logic           w_host_accept;
    logic           w_unused_do;

    // Macro read data goes straight to the multiplier; the controller never
    // looks at it.
    assign w_unused_do = ^mem_do;

    assign w_len_clamp = (len > 8'd128) ? 8'd128 : len;
    assign w_count_inc = r_count + 8'd1;
    assign w_cur_inc   = r_cur + 7'd1;

    // The host is taken from IDLE (start wins) and also directly from FIN, so
    // a request held through a run is granted in the cycle after done.
    assign w_host_accept = host_req &&
                           (((r_state == ST_IDLE) && !start) || (r_state == ST_FIN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_len         <= '0;
            r_count       <= '0;
            r_wait        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_wr     <= 1'b0;
            r_wdata       <= '0;
            r_ra          <= '0;
            r_ca          <= '0;
            r_nce         <= 1'b1;
            r_nwrt        <= 1'b1;
        end else begin
            // Control pins are registered: each branch loads the values the
            // macro must see during the state being entered.
            r_done        <= 1'b0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_nce         <= 1'b1;
            r_nwrt        <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur   <= base_addr;
                        r_len   <= w_len_clamp;
                        r_count <= '0;
                        if (w_len_clamp == 8'd0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= ST_RD;
                            r_busy        <= 1'b1;
                            r_nce         <= 1'b0;
                            {r_ra, r_ca}  <= base_addr;
                        end
                    end else if (host_req) begin
                        r_state <= ST_HOST;
                    end
                end

                ST_HOST: begin
                    r_state       <= ST_IDLE;
                    r_host_rvalid <= ~r_host_wr;
                end

                ST_RD: begin
                    r_state <= ST_MWAIT;
                    r_wait  <= WCW'(MUL_LAT - 1);
                end

                ST_MWAIT: begin
                    if (r_wait == '0) begin
                        r_state      <= ST_WR;
                        r_nce        <= 1'b0;
                        r_nwrt       <= 1'b0;
                        {r_ra, r_ca} <= r_cur;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end

                ST_WR: begin
                    r_count <= w_count_inc;
                    r_cur   <= w_cur_inc;
                    if (w_count_inc == r_len) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state      <= ST_RD;
                        r_nce        <= 1'b0;
                        {r_ra, r_ca} <= w_cur_inc;
                    end
                end

                ST_FIN: begin
                    r_state <= host_req ? ST_HOST : ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_host_accept) begin
                r_host_wr    <= host_wr;
                r_wdata      <= host_wdata;
                r_host_gnt   <= 1'b1;
                r_nce        <= 1'b0;
                r_nwrt       <= ~host_wr;
                {r_ra, r_ca} <= host_addr;
            end
        end
    end

    always_comb begin
        mem_din = mul_out;
        if ((r_state == ST_HOST) && r_host_wr) begin
            mem_din = r_wdata;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign count       = r_count;
    assign host_gnt    = r_host_gnt;
    assign host_rvalid = r_host_rvalid;
    assign RA          = r_ra;
    assign CA          = r_ca;
    assign NCE         = r_nce;
    assign NWRT        = r_nwrt;

endmodule

// File: tb/tb_mem_mul_sequencer.sv
// Bench for mem_mul_sequencer with a behavioural macro and multiplier model.
module tb_mem_mul_sequencer;

    localparam int unsigned MUL_LAT = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [7:0]  len = '0;
    logic        busy, done;
    logic [7:0]  count;
    logic        host_req = 1'b0;
    logic        host_wr = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [51:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [51:0] mem_do;
    logic [51:0] mul_out;
    logic [51:0] mem_din;
    logic [4:0]  RA;
    logic [1:0]  CA;
    logic        NCE, NWRT;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned run_gnts;
    logic [6:0]  wb_addr[$];
    logic [51:0] wb_data[$];

    mem_mul_sequencer #(.MUL_LAT(MUL_LAT), .AW(7), .DW(52)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .count(count),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .mem_do(mem_do), .mul_out(mul_out), .mem_din(mem_din),
        .RA(RA), .CA(CA), .NCE(NCE), .NWRT(NWRT)
    );

    always #5 clk = ~clk;

    // Macro model: control sampled at the rising edge, read data next cycle.
    logic [51:0] mem [128];
    logic [51:0] r_do = '0;
    assign mem_do = r_do;
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (!NCE) begin
            if (!NWRT) mem[{RA, CA}] <= mem_din;
            else       r_do <= mem[{RA, CA}];
        end
    end

    // Multiplier model: samples mem_do every edge, product MUL_LAT edges later.
    logic [51:0] mp [MUL_LAT];
    initial for (int i = 0; i < MUL_LAT; i++) mp[i] = '0;
    always @(posedge clk) begin
        mp[0] <= 52'(r_do[51:26]) * 52'(r_do[25:0]);
        for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mul_out = mp[MUL_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag);
        int unsigned k = 0;
        tick();
        while (!host_gnt && k < 20) begin
            tick();
            k++;
        end
        if (!host_gnt) check({tag, "_gnt_timeout"}, 64'(host_gnt), 64'd1);
    endtask

    task automatic host_write(input logic [6:0] a, input logic [51:0] d);
        host_req = 1'b1; host_wr = 1'b1; host_addr = a; host_wdata = d;
        wait_gnt("hw");
        host_req = 1'b0;
        tick();
    endtask

    task automatic host_read(input logic [6:0] a, input logic [51:0] exp, input string tag);
        host_req = 1'b1; host_wr = 1'b0; host_addr = a;
        wait_gnt(tag);
        host_req = 1'b0;
        tick();
        check({tag, "_rvalid"}, 64'(host_rvalid), 64'd1);
        check(tag, 64'(mem_do), 64'(exp));
    endtask

    // Starts a run and returns in the done cycle (or after the cycle budget).
    task automatic run(input logic [6:0] b, input logic [7:0] l, input int unsigned exp_cyc,
                       input bit raise_req, input string tag);
        int unsigned n;
        bit seen = 1'b0;
        wb_addr.delete();
        wb_data.delete();
        run_gnts = 0;
        start = 1'b1; base_addr = b; len = l;
        tick();
        start = 1'b0;
        if (raise_req) host_req = 1'b1;
        n = 1;
        while (n < 1000) begin
            if (host_gnt) run_gnts++;
            if (!NCE && !NWRT) begin
                wb_addr.push_back({RA, CA});
                wb_data.push_back(mem_din);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [51:0] v;
        int unsigned dones;

        tick(); tick();
        rstn = 1'b1;
        tick();

        // Reset state
        check("rst_NCE", 64'(NCE), 64'd1);
        check("rst_NWRT", 64'(NWRT), 64'd1);
        check("rst_addr", 64'({RA, CA}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_gnt", 64'(host_gnt), 64'd0);
        check("rst_rvalid", 64'(host_rvalid), 64'd0);

        // 1: single word, 3*7 = 21
        v = {26'd3, 26'd7};
        host_write(7'd5, v);
        run(7'd5, 8'd1, 5, 1'b0, "t1");
        check("t1_count", 64'(count), 64'd1);
        check("t1_busy_fin", 64'(busy), 64'd0);
        tick();
        host_read(7'd5, 52'd21, "t1_rd5");

        // 2: wrapping range 126,127,0,1
        host_write(7'd126, {26'd2, 26'd3});
        host_write(7'd127, {26'd3, 26'd4});
        host_write(7'd0,   {26'd4, 26'd5});
        host_write(7'd1,   {26'd5, 26'd6});
        host_write(7'd2,   {26'd7, 26'd8});
        run(7'd126, 8'd4, 17, 1'b0, "t2");
        check("t2_count", 64'(count), 64'd4);
        check("t2_nwb", 64'(wb_addr.size()), 64'd4);
        if (wb_addr.size() == 4) begin
            check("t2_a0", 64'(wb_addr[0]), 64'd126);
            check("t2_a1", 64'(wb_addr[1]), 64'd127);
            check("t2_a2", 64'(wb_addr[2]), 64'd0);
            check("t2_a3", 64'(wb_addr[3]), 64'd1);
            check("t2_d0", 64'(wb_data[0]), 64'd6);
            check("t2_d1", 64'(wb_data[1]), 64'd12);
            check("t2_d2", 64'(wb_data[2]), 64'd20);
            check("t2_d3", 64'(wb_data[3]), 64'd30);
        end
        tick();
        host_read(7'd2, {26'd7, 26'd8}, "t2_rd2");
        host_read(7'd127, 52'd12, "t2_rd127");

        // 3: len = 0
        run(7'd40, 8'd0, 1, 1'b0, "t3");
        check("t3_NCE", 64'(NCE), 64'd1);
        check("t3_count", 64'(count), 64'd0);
        check("t3_nwb", 64'(wb_addr.size()), 64'd0);
        tick();

        // 4: start and host_req together; start wins, host granted after done
        host_req = 1'b1; host_wr = 1'b0; host_addr = 7'd5;
        run(7'd10, 8'd1, 5, 1'b0, "t4");
        check("t4_gnts_busy", 64'(run_gnts), 64'd0);
        tick();
        check("t4_gnt_after", 64'(host_gnt), 64'd1);
        host_req = 1'b0;
        tick();
        check("t4_rvalid", 64'(host_rvalid), 64'd1);
        check("t4_rdata", 64'(mem_do), 64'd21);
        tick();

        // 5: host request raised during a len=3 run
        host_wr = 1'b1; host_addr = 7'd40; host_wdata = 52'h5_A5A5_1234_5678;
        run(7'd20, 8'd3, 13, 1'b1, "t5");
        check("t5_gnts_busy", 64'(run_gnts), 64'd0);
        tick();
        check("t5_gnt_after", 64'(host_gnt), 64'd1);
        host_req = 1'b0;
        run_gnts = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (host_gnt) run_gnts++;
        end
        check("t5_total_gnts", 64'(run_gnts), 64'd1);
        host_read(7'd40, 52'h5_A5A5_1234_5678, "t5_rd40");

        // 6: reset in the first MWAIT cycle of word 2
        host_write(7'd60, {26'd2, 26'd3});
        host_write(7'd61, {26'd4, 26'd5});
        host_write(7'd62, {26'd6, 26'd7});
        host_write(7'd63, {26'd8, 26'd9});
        start = 1'b1; base_addr = 7'd60; len = 8'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_busy_pre", 64'(busy), 64'd1);
        check("t6_count_pre", 64'(count), 64'd1);
        rstn = 1'b0;
        #1;
        check("t6_NCE_async", 64'(NCE), 64'd1);
        check("t6_busy_async", 64'(busy), 64'd0);
        check("t6_count_async", 64'(count), 64'd0);
        #2;
        rstn = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("t6_no_done", 64'(dones), 64'd0);
        host_read(7'd60, 52'd6, "t6_rd60");
        host_read(7'd61, {26'd4, 26'd5}, "t6_rd61");
        host_read(7'd62, {26'd6, 26'd7}, "t6_rd62");
        host_read(7'd63, {26'd8, 26'd9}, "t6_rd63");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
